imem_axi_rd_slave: RTL and testbench
====================================

IMEM_AXI_RD_SLAVE -- requirements
Module: imem_axi_rd_slave

Interface
REQ-001 SHALL have parameter AxiIdWidth, default 4, width of AR/R ID fields.
REQ-002 SHALL have parameter DepthWords, default 1024, number of 64-bit memory words (power of two).
REQ-003 SHALL have parameter BaseAddr, default 32'h0000_0000, byte address of word 0 (aligned to DepthWords*8).
REQ-004 SHALL have clock and reset ports: clk in 1, rising-edge clock; rst in 1, reset, asynchronous, active-high.
REQ-005 SHALL have AR channel inputs: axi_arid AxiIdWidth, axi_araddr 32, axi_arlen 8, axi_arsize 3, axi_arburst 2, axi_arvalid 1, all AXI4 read-address fields from the initiator.
REQ-006 SHALL have AR channel output axi_arready 1, address accept.
REQ-007 SHALL have R channel outputs: axi_rid AxiIdWidth, axi_rdata 64, axi_rresp 2, axi_rlast 1, axi_rvalid 1.
REQ-008 SHALL have R channel input axi_rready 1, beat accept.
REQ-009 SHALL have preload port inputs: mem_we 1, write strobe; mem_waddr $clog2(DepthWords), word index; mem_wdata 64, word data.
REQ-010 SHALL ignore axi_arlock, axi_arcache, axi_arprot, axi_arqos and axi_arregion; these ports are not present.

Function
REQ-011 SHALL implement FSM IDLE/BURST with one outstanding burst and no read reordering.
REQ-012 SHALL drive axi_arready=1 only in IDLE; an AR handshake in IDLE captures id, addr, len, size and burst, sets beat count to 0, and moves to BURST.
REQ-013 SHALL assert axi_rvalid on the cycle after the AR handshake (1-cycle latency), with beat 0 registered on the handshake edge.
REQ-014 SHALL hold axi_rid/rdata/rresp/rlast stable while axi_rvalid=1 and axi_rready=0.
REQ-015 SHALL load the next beat on the same edge as an R handshake, sustaining one beat per cycle while axi_rready=1.
REQ-016 SHALL return as rdata the memory word at index (addr - BaseAddr)[..:3]; narrower sizes return the full aligned 64-bit word.
REQ-017 SHALL advance beat address as follows: FIXED (00) unchanged; INCR (01) +2^arsize, first increment from the size-aligned address, no 4 KB boundary check; WRAP (10) +2^arsize, wrapping within a (arlen+1)*2^arsize aligned window.
REQ-018 SHALL drive axi_rresp=SLVERR (2'b10) and rdata=0 for a beat whose address is outside [BaseAddr, BaseAddr+DepthWords*8); in-range beats return OKAY (2'b00).
REQ-019 SHALL return all beats as SLVERR, rdata=0, for any of: arsize>3; arburst=2'b11; WRAP with arlen not in {1,3,7,15}. The beat count still equals arlen+1.
REQ-020 SHALL assert axi_rlast only on beat arlen; the R handshake of that beat returns the FSM to IDLE, with axi_arready=1 on the next cycle.
REQ-021 SHALL write mem_wdata to mem_waddr on a clk edge with mem_we=1, in any state.
REQ-022 SHALL return the old word when mem_we hits the word being loaded for a beat on the same edge.
REQ-023 SHALL echo the captured arid on axi_rid for every beat.

Reset
REQ-024 SHALL, while rst=1, force axi_arready=0, axi_rvalid=0, axi_rlast=0, axi_rdata=0, axi_rresp=0, axi_rid=0, and FSM=IDLE.
REQ-025 SHALL, on rst assertion mid-burst, drop axi_rvalid immediately and discard the remaining beats.
REQ-026 SHALL leave memory contents unaffected by reset.
REQ-027 SHALL raise axi_arready on the first clk edge after rst deasserts.

Verification
REQ-028 SHALL cover: preload words 0..3 = 64'h1..64'h4; AR addr=0, len=3, size=3, INCR, id=2, rready=1 -> 4 consecutive beats 1,2,3,4, rid=2, OKAY, rlast on beat 4 only, first rvalid 1 cycle after the AR handshake.
REQ-029 SHALL cover: WRAP len=3, size=3, addr=0x10 -> word order 2,3,0,1, rlast on 4th beat.
REQ-030 SHALL cover: rready toggled 1,0,0,1 during an INCR burst -> rdata/rresp/rlast held stable during stall, no beat lost or duplicated.
REQ-031 SHALL cover: INCR len=1 at addr BaseAddr+DepthWords*8-8 -> beat 0 OKAY, beat 1 SLVERR rdata=0; arsize=4 -> all beats SLVERR.
REQ-032 SHALL cover: rst pulsed after beat 1 of a len=7 burst -> rvalid=0 immediately, arready=1 one edge after release, new burst returns the preloaded data unchanged.
REQ-033 SHALL cover: mem_we to word 5 on the edge loading word 5 -> old value returned; a re-read returns the new value.

Source files
------------

// File: rtl/imem_axi_rd_slave_if.sv
// AXI4 read-only channel bundle (AR + R) between an initiator and the imem read slave.
interface imem_axi_rd_slave_if #(
    parameter int AxiIdWidth = 4
);
    logic [AxiIdWidth-1:0] axi_arid;
    logic [31:0]           axi_araddr;
    logic [7:0]            axi_arlen;
    logic [2:0]            axi_arsize;
    logic [1:0]            axi_arburst;
    logic                  axi_arvalid;
    logic                  axi_arready;
    logic [AxiIdWidth-1:0] axi_rid;
    logic [63:0]           axi_rdata;
    logic [1:0]            axi_rresp;
    logic                  axi_rlast;
    logic                  axi_rvalid;
    logic                  axi_rready;

    modport slave (
        input  axi_arid, axi_araddr, axi_arlen, axi_arsize, axi_arburst, axi_arvalid, axi_rready,
        output axi_arready, axi_rid, axi_rdata, axi_rresp, axi_rlast, axi_rvalid
    );

    modport master (
        output axi_arid, axi_araddr, axi_arlen, axi_arsize, axi_arburst, axi_arvalid, axi_rready,
        input  axi_arready, axi_rid, axi_rdata, axi_rresp, axi_rlast, axi_rvalid
    );
endinterface

// File: rtl/imem_axi_rd_slave.sv
// 64-bit instruction memory behind an AXI4 read-only slave: one burst at a time,
// one beat per cycle, preloaded through a simple word write port.
module imem_axi_rd_slave #(
    parameter int          AxiIdWidth = 4,
    parameter int          DepthWords = 1024,
    parameter logic [31:0] BaseAddr   = 32'h0000_0000
) (
    input  logic                          clk,
    input  logic                          rst,
    imem_axi_rd_slave_if.slave            axi,
    input  logic                          mem_we,
    input  logic [$clog2(DepthWords)-1:0] mem_waddr,
    input  logic [63:0]                   mem_wdata
);
    localparam int          AW       = $clog2(DepthWords);
    localparam logic [32:0] MemBytes = 33'(DepthWords) << 3;

    typedef enum logic {IDLE, BURST} state_t;

    state_t                state;
    logic [63:0]           mem [DepthWords];
    logic [AxiIdWidth-1:0] id_q;
    logic [31:0]           addr_q;
    logic [7:0]            len_q;
    logic [7:0]            beat_q;
    logic [2:0]            size_q;
    logic [1:0]            burst_q;
    logic                  bad_q;
    logic                  arready_q;
    logic                  rvalid_q;
    logic                  rlast_q;
    logic [63:0]           rdata_q;
    logic [1:0]            rresp_q;

    assign axi.axi_arready = arready_q;
    assign axi.axi_rvalid  = rvalid_q;
    assign axi.axi_rlast   = rlast_q;
    assign axi.axi_rdata   = rdata_q;
    assign axi.axi_rresp   = rresp_q;
    assign axi.axi_rid     = id_q;

    // Requests the slave cannot legally serve: every beat comes back SLVERR.
    logic ar_bad;
    always_comb begin
        ar_bad = (axi.axi_arsize > 3'd3) || (axi.axi_arburst == 2'b11) ||
                 ((axi.axi_arburst == 2'b10) &&
                  !(axi.axi_arlen inside {8'd1, 8'd3, 8'd7, 8'd15}));
    end

    logic [31:0] incr, wmask, nxt_addr;
    always_comb begin
        incr  = 32'd1 << size_q;
        wmask = (({24'd0, len_q} + 32'd1) << size_q) - 32'd1;
        case (burst_q)
            2'b00:   nxt_addr = addr_q;
            2'b10:   nxt_addr = (addr_q & ~wmask) | ((addr_q + incr) & wmask);
            default: nxt_addr = (addr_q & ~(incr - 32'd1)) + incr;
        endcase
    end

    // Beat source: the AR address on the handshake edge, else the advanced address.
    logic [31:0] ld_addr, ld_off;
    logic        ld_bad, ld_err;
    logic [63:0] ld_data;
    always_comb begin
        ld_addr = (state == IDLE) ? axi.axi_araddr : nxt_addr;
        ld_bad  = (state == IDLE) ? ar_bad : bad_q;
        ld_off  = ld_addr - BaseAddr;
        ld_err  = ld_bad || ({1'b0, ld_off} >= MemBytes);
        ld_data = ld_err ? 64'd0 : mem[ld_off[3 +: AW]];
    end

    // Memory is outside the reset domain so a reset keeps the preloaded image.
    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_waddr] <= mem_wdata;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= '0;
            id_q      <= '0;
            addr_q    <= '0;
            len_q     <= '0;
            beat_q    <= '0;
            size_q    <= '0;
            burst_q   <= '0;
            bad_q     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    arready_q <= 1'b1;
                    if (arready_q && axi.axi_arvalid) begin
                        id_q      <= axi.axi_arid;
                        addr_q    <= axi.axi_araddr;
                        len_q     <= axi.axi_arlen;
                        size_q    <= axi.axi_arsize;
                        burst_q   <= axi.axi_arburst;
                        bad_q     <= ar_bad;
                        beat_q    <= 8'd0;
                        arready_q <= 1'b0;
                        rvalid_q  <= 1'b1;
                        rdata_q   <= ld_data;
                        rresp_q   <= ld_err ? 2'b10 : 2'b00;
                        rlast_q   <= (axi.axi_arlen == 8'd0);
                        state     <= BURST;
                    end
                end
                BURST: begin
                    if (axi.axi_rready) begin
                        if (rlast_q) begin
                            rvalid_q  <= 1'b0;
                            rlast_q   <= 1'b0;
                            arready_q <= 1'b1;
                            state     <= IDLE;
                        end else begin
                            beat_q  <= beat_q + 8'd1;
                            addr_q  <= nxt_addr;
                            rdata_q <= ld_data;
                            rresp_q <= ld_err ? 2'b10 : 2'b00;
                            rlast_q <= ((beat_q + 8'd1) == len_q);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_imem_axi_rd_slave.sv
// Bench for imem_axi_rd_slave: directed table, hand-written corner sequences and
// random bursts, all checked against a shadow memory and a burst address model.
module tb_imem_axi_rd_slave;
    localparam int          IDW   = 4;
    localparam int          DEPTH = 64;
    localparam logic [31:0] BASE  = 32'h0000_1000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_we = 1'b0;
    logic [5:0]  mem_waddr = '0;
    logic [63:0] mem_wdata = '0;

    always #5 clk = ~clk;

    imem_axi_rd_slave_if #(.AxiIdWidth(IDW)) axi ();

    imem_axi_rd_slave #(.AxiIdWidth(IDW), .DepthWords(DEPTH), .BaseAddr(BASE)) dut (
        .clk       (clk),
        .rst       (rst),
        .axi       (axi.slave),
        .mem_we    (mem_we),
        .mem_waddr (mem_waddr),
        .mem_wdata (mem_wdata)
    );

    logic [63:0] shadow [DEPTH];
    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [IDW-1:0] id;
        logic [31:0]    addr;
        int             len, size, burst, mode;
        int             exp_beats;
        logic [63:0]    exp_d0;
        logic [1:0]     exp_r0;
    } vec_t;

    // Address of beat i straight from the AXI burst rules.
    function automatic logic [31:0] beat_addr(input logic [31:0] a, input int len,
                                              input int size, input int burst, input int i);
        longint unsigned sz, win, base, aa;
        aa = a;
        sz = 64'd1 << size;
        if (burst == 0) return a;
        if (burst == 2) begin
            win  = longint'(len + 1) * sz;
            base = aa - aa % win;
            return 32'(base + (aa - base + longint'(i) * sz) % win);
        end
        if (i == 0) return a;
        return 32'(aa - aa % sz + longint'(i) * sz);
    endfunction

    function automatic logic [63:0] init_word(input int i);
        return (i < 4) ? 64'(i + 1) : (64'hDEAD_0000_0000_0000 | 64'(i));
    endfunction

    task automatic preload(input int idx, input logic [63:0] d);
        mem_we    = 1'b1;
        mem_waddr = 6'(idx);
        mem_wdata = d;
        @(posedge clk); @(negedge clk);
        mem_we = 1'b0;
        shadow[idx] = d;
    endtask

    // Issue one burst and check every beat; entered and left on a negedge.
    task automatic run_burst(input logic [IDW-1:0] id, input logic [31:0] addr,
                             input int len, input int size, input int burst,
                             input int mode, input int rst_after,
                             input bit col_en, input int col_idx, input logic [63:0] col_data,
                             output int nbeats, output logic [63:0] d0, output logic [1:0] r0);
        logic [63:0] ed [16];
        logic [1:0]  er [16];
        logic [31:0] ba;
        bit          bad, inr, rr;
        int          t, k, cyc;
        nbeats = 0; d0 = 'x; r0 = 'x;
        bad = (size > 3) || (burst == 3) || (burst == 2 && !(len inside {1, 3, 7, 15}));
        for (int i = 0; i <= len; i++) begin
            ba  = beat_addr(addr, len, size, burst, i);
            inr = (longint'(ba) >= longint'(BASE)) && (longint'(ba) < longint'(BASE) + DEPTH * 8);
            if (bad || !inr) begin ed[i] = 64'd0; er[i] = 2'b10; end
            else begin ed[i] = shadow[(ba - BASE) >> 3]; er[i] = 2'b00; end
        end
        axi.axi_arid    = id;
        axi.axi_araddr  = addr;
        axi.axi_arlen   = 8'(len);
        axi.axi_arsize  = 3'(size);
        axi.axi_arburst = 2'(burst);
        axi.axi_arvalid = 1'b1;
        if (col_en) begin mem_we = 1'b1; mem_waddr = 6'(col_idx); mem_wdata = col_data; end
        t = 0;
        while (!axi.axi_arready && t < 50) begin @(negedge clk); t++; end
        if (t == 50) begin
            checks++; failures++;
            $display("FAIL ar_timeout: arready never seen high, want 1");
            axi.axi_arvalid = 1'b0; mem_we = 1'b0;
            return;
        end
        @(posedge clk); @(negedge clk);
        axi.axi_arvalid = 1'b0;
        mem_we = 1'b0;
        if (col_en) shadow[col_idx] = col_data;
        checks++;
        if (axi.axi_rvalid !== 1'b1) begin
            failures++;
            $display("FAIL r_latency: rvalid=%b one cycle after AR, want 1", axi.axi_rvalid);
        end
        k = 0; cyc = 0;
        while (k <= len && cyc < 400) begin
            if (rst_after >= 0 && k == rst_after) begin
                rst = 1'b1;
                #1;
                checks++;
                if (axi.axi_rvalid !== 1'b0 || axi.axi_arready !== 1'b0 || axi.axi_rlast !== 1'b0 ||
                    axi.axi_rdata !== 64'd0 || axi.axi_rresp !== 2'd0 || axi.axi_rid !== '0) begin
                    failures++;
                    $display("FAIL rst_mid_burst: rvalid=%b arready=%b rlast=%b rdata=%h rresp=%0d rid=%0h, want all 0",
                             axi.axi_rvalid, axi.axi_arready, axi.axi_rlast, axi.axi_rdata, axi.axi_rresp, axi.axi_rid);
                end
                axi.axi_rready = 1'b0;
                @(negedge clk); rst = 1'b0;
                @(negedge clk);
                checks++;
                if (axi.axi_arready !== 1'b1) begin
                    failures++;
                    $display("FAIL arready_after_rst: arready=%b, want 1", axi.axi_arready);
                end
                nbeats = k;
                return;
            end
            case (mode)
                0:       rr = 1'b1;
                1:       rr = (cyc % 4 == 0) || (cyc % 4 == 3);
                default: rr = 1'($urandom_range(0, 1));
            endcase
            axi.axi_rready = rr;
            if (axi.axi_rvalid) begin
                checks++;
                if (axi.axi_rid !== id || axi.axi_rdata !== ed[k] || axi.axi_rresp !== er[k] ||
                    axi.axi_rlast !== (k == len)) begin
                    failures++;
                    $display("FAIL beat%0d: rid=%0h rdata=%h rresp=%0d rlast=%b, want rid=%0h rdata=%h rresp=%0d rlast=%b",
                             k, axi.axi_rid, axi.axi_rdata, axi.axi_rresp, axi.axi_rlast,
                             id, ed[k], er[k], (k == len));
                end
                if (k == 0) begin d0 = axi.axi_rdata; r0 = axi.axi_rresp; end
                if (rr) k++;
            end
            @(posedge clk); @(negedge clk);
            cyc++;
        end
        axi.axi_rready = 1'b0;
        nbeats = k;
        checks++;
        if (k <= len) begin
            failures++;
            $display("FAIL r_timeout: got %0d beats, want %0d", k, len + 1);
        end else if (axi.axi_arready !== 1'b1 || axi.axi_rvalid !== 1'b0) begin
            failures++;
            $display("FAIL idle_after: arready=%b rvalid=%b, want arready=1 rvalid=0",
                     axi.axi_arready, axi.axi_rvalid);
        end
    endtask

    vec_t        vt [10];
    int          nb, len, size, burst;
    logic [63:0] d0;
    logic [1:0]  r0;
    logic [31:0] addr;

    initial begin
        axi.axi_arid = '0; axi.axi_araddr = '0; axi.axi_arlen = '0; axi.axi_arsize = '0;
        axi.axi_arburst = '0; axi.axi_arvalid = 1'b0; axi.axi_rready = 1'b0;

        vt[0] = '{4'd2, BASE,           3, 3, 1, 0, 4, 64'd1, 2'd0};
        vt[1] = '{4'd1, BASE + 32'h10,  3, 3, 2, 0, 4, 64'd3, 2'd0};
        vt[2] = '{4'd7, BASE,           3, 3, 1, 1, 4, 64'd1, 2'd0};
        vt[3] = '{4'd3, BASE + 32'h1F8, 1, 3, 1, 0, 2, 64'hDEAD_0000_0000_003F, 2'd0};
        vt[4] = '{4'd4, BASE,           2, 4, 1, 0, 3, 64'd0, 2'd2};
        vt[5] = '{4'd5, BASE,           0, 3, 3, 0, 1, 64'd0, 2'd2};
        vt[6] = '{4'd6, BASE,           2, 3, 2, 0, 3, 64'd0, 2'd2};
        vt[7] = '{4'd8, BASE + 32'h28,  2, 3, 0, 1, 3, 64'hDEAD_0000_0000_0005, 2'd0};
        vt[8] = '{4'd9, BASE + 32'h4,   3, 2, 1, 0, 4, 64'd1, 2'd0};
        vt[9] = '{4'hA, BASE - 32'h8,   1, 3, 1, 0, 2, 64'd0, 2'd2};

        @(negedge clk); @(negedge clk);
        checks++;
        if (axi.axi_arready !== 1'b0 || axi.axi_rvalid !== 1'b0 || axi.axi_rlast !== 1'b0 ||
            axi.axi_rdata !== 64'd0 || axi.axi_rresp !== 2'd0 || axi.axi_rid !== '0) begin
            failures++;
            $display("FAIL reset_state: arready=%b rvalid=%b rlast=%b rdata=%h rresp=%0d rid=%0h, want all 0",
                     axi.axi_arready, axi.axi_rvalid, axi.axi_rlast, axi.axi_rdata, axi.axi_rresp, axi.axi_rid);
        end
        for (int i = 0; i < DEPTH; i++) preload(i, init_word(i));
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (axi.axi_arready !== 1'b1) begin
            failures++;
            $display("FAIL arready_rise: arready=%b one edge after reset release, want 1", axi.axi_arready);
        end

        foreach (vt[v]) begin
            run_burst(vt[v].id, vt[v].addr, vt[v].len, vt[v].size, vt[v].burst, vt[v].mode,
                      -1, 1'b0, 0, 64'd0, nb, d0, r0);
            checks++;
            if (nb != vt[v].exp_beats || d0 !== vt[v].exp_d0 || r0 !== vt[v].exp_r0) begin
                failures++;
                $display("FAIL vec%0d: beats=%0d d0=%h r0=%0d, want beats=%0d d0=%h r0=%0d",
                         v, nb, d0, r0, vt[v].exp_beats, vt[v].exp_d0, vt[v].exp_r0);
            end
        end

        // Reset after beat 1 of an 8-beat burst, then the image must still be intact.
        run_burst(4'd3, BASE, 7, 3, 1, 0, 2, 1'b0, 0, 64'd0, nb, d0, r0);
        run_burst(4'd3, BASE, 7, 3, 1, 0, -1, 1'b0, 0, 64'd0, nb, d0, r0);
        checks++;
        if (nb != 8 || d0 !== 64'd1) begin
            failures++;
            $display("FAIL post_rst_burst: beats=%0d d0=%h, want beats=8 d0=%h", nb, d0, 64'd1);
        end

        // Write to word 5 on the very edge that loads it.
        run_burst(4'd5, BASE + 32'h28, 0, 3, 1, 0, -1, 1'b1, 5, 64'h5555_AAAA_5555_AAAA, nb, d0, r0);
        checks++;
        if (d0 !== 64'hDEAD_0000_0000_0005) begin
            failures++;
            $display("FAIL collide_old: rdata=%h, want %h", d0, 64'hDEAD_0000_0000_0005);
        end
        run_burst(4'd5, BASE + 32'h28, 0, 3, 1, 0, -1, 1'b0, 0, 64'd0, nb, d0, r0);
        checks++;
        if (d0 !== 64'h5555_AAAA_5555_AAAA) begin
            failures++;
            $display("FAIL collide_new: rdata=%h, want %h", d0, 64'h5555_AAAA_5555_AAAA);
        end

        for (int n = 0; n < 40; n++) begin
            burst = ($urandom_range(0, 9) == 0) ? 3 : int'($urandom_range(0, 2));
            size  = ($urandom_range(0, 9) == 0) ? int'($urandom_range(4, 7)) : int'($urandom_range(0, 3));
            if (burst == 2 && $urandom_range(0, 7) != 0) len = (2 << $urandom_range(0, 3)) - 1;
            else len = $urandom_range(0, 15);
            case ($urandom_range(0, 15))
                0:       addr = BASE - 32'h8;
                1, 2:    addr = BASE + DEPTH * 8 - 8 * $urandom_range(1, 3);
                default: begin
                    addr = BASE + $urandom_range(0, DEPTH * 8 - 1);
                    if (size <= 3) addr = addr & ~((32'd1 << size) - 32'd1);
                end
            endcase
            if ($urandom_range(0, 3) == 0) preload($urandom_range(0, DEPTH - 1), {$urandom, $urandom});
            repeat ($urandom_range(0, 2)) @(negedge clk);
            run_burst(IDW'($urandom_range(0, 15)), addr, len, size, burst, 2, -1, 1'b0, 0, 64'd0,
                      nb, d0, r0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, want completion");
        $fatal(1, "watchdog expired");
    end
endmodule
